imem_loadable: RTL and testbench

//  Parametrised, synchronous, run-time loadable instruction memory for the RISC-V core.

---
 rtl/imem_loadable_pkg.sv | 14 +
 rtl/imem_loadable_array.sv | 24 ++
 rtl/imem_loadable.sv | 128 ++++++++++++
 tb/tb_imem_loadable.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loadable_pkg.sv
// Shared constants and types for the loadable instruction memory.
package imem_loadable_pkg;

    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [1:0]  FAULT_NONE  = 2'b00;
    localparam logic [1:0]  FAULT_MISAL = 2'b01;
    localparam logic [1:0]  FAULT_RANGE = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/imem_loadable_array.sv
// Instruction storage: one synchronous write port, one synchronous read port, no reset.
module imem_loadable_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rd_data only moves on a read, so it doubles as the held response word
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: registered fetch port with backpressure,
// streaming program-load port, misaligned/out-of-range fault reporting.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | fetches accepted, load port idle until ld_start
//   ST_LOAD | load beats written at ld_idx, fetch port closed
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_fault,
    input  logic              rsp_ready,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done
);

    localparam int CNT_W = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  ld_idx, ld_idx_nxt;
    logic              ld_done_nxt;
    logic              ld_acc;
    logic              fetch_acc;
    logic              rd_en;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        fault;
    logic [DATA_W-1:0] rd_data;

    assign word_idx = fetch_addr[ADDR_W-1:2];

    // Misalignment wins over range; the full word index is compared, so no aliasing
    always_comb begin
        fault = FAULT_NONE;
        if (fetch_addr[1:0] != 2'b00)
            fault = FAULT_MISAL;
        else if (word_idx > (ADDR_W-2)'(DEPTH-1))
            fault = FAULT_RANGE;
    end

    always_comb begin
        state_nxt   = state;
        ld_idx_nxt  = ld_idx;
        ld_done_nxt = 1'b0;
        fetch_ready = 1'b0;
        ld_ready    = 1'b0;
        ld_acc      = 1'b0;
        case (state)
            ST_RUN: begin
                fetch_ready = !rsp_valid || rsp_ready;
                if (ld_start) begin
                    ld_idx_nxt = '0;
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = !ld_start;
                ld_acc   = ld_valid && !ld_start;
                if (ld_start) begin
                    ld_idx_nxt = '0;
                end else if (ld_acc) begin
                    ld_idx_nxt = ld_idx + 1'b1;
                    if (ld_last || ld_idx == CNT_W'(DEPTH-1)) begin
                        ld_idx_nxt  = '0;
                        ld_done_nxt = 1'b1;
                        state_nxt   = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign fetch_acc = fetch_valid && fetch_ready;
    assign rd_en     = fetch_acc && (fault == FAULT_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ld_idx    <= '0;
            ld_done   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_fault <= FAULT_NONE;
        end else begin
            state   <= state_nxt;
            ld_idx  <= ld_idx_nxt;
            ld_done <= ld_done_nxt;
            if (fetch_acc) begin
                rsp_valid <= 1'b1;
                rsp_fault <= fault;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Faulted fetches never read the array; they report a NOP instead
    assign rsp_data = !rsp_valid                ? '0 :
                      (rsp_fault != FAULT_NONE) ? DATA_W'(NOP_INSN) : rd_data;

    imem_loadable_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (ld_acc),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_idx  (word_idx[CNT_W-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: fetch table, scoreboard of responses, load corner cases.
module tb_imem_loadable;

    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst_n;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        ld_start, ld_valid, ld_last, ld_ready, ld_done;
    logic [31:0] ld_data;

    imem_loadable #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault), .rsp_ready(rsp_ready),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } vec_t;

    rsp_t        sb[$];
    vec_t        tbl[10];
    logic [31:0] mm[DEPTH];
    logic [31:0] nxt_data;
    logic [1:0]  nxt_fault;
    logic        exp_valid, fr_s, ld_acc;
    int          ld_idx, done_cnt;
    int          n_cmp, n_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fetch_exp(input logic [31:0] a);
        if (a[1:0] != 2'b00) begin
            nxt_data = NOP; nxt_fault = 2'b01;
        end else if (a[31:2] >= 30'(DEPTH)) begin
            nxt_data = NOP; nxt_fault = 2'b10;
        end else begin
            nxt_data = mm[a[7:2]]; nxt_fault = 2'b00;
        end
    endtask

    // One clock: sample at the falling edge, then step to just after the rising edge
    task automatic cycle();
        logic acc;
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL sb_underflow: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                chk("rsp_data", rsp_data, sb[0].data);
                chk("rsp_fault", 32'(rsp_fault), 32'(sb[0].fault));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        fr_s   = fetch_ready;
        acc    = fetch_valid && fetch_ready;
        ld_acc = ld_valid && ld_ready;
        if (acc) sb.push_back('{nxt_data, nxt_fault});
        exp_valid = acc || (exp_valid && !rsp_ready);
        if (ld_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic ld_beat(input logic [31:0] d, input logic last, input logic exp_acc);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        cycle();
        chk("ld_ready", 32'(ld_acc), 32'(exp_acc));
        if (exp_acc) begin
            mm[ld_idx] = d;
            ld_idx++;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic ld_pulse();
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        ld_idx = 0;
    endtask

    task automatic fetch_one(input logic [31:0] a, input string name);
        fetch_valid = 1'b1; fetch_addr = a;
        fetch_exp(a);
        cycle();
        chk(name, 32'(fr_s), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0050_0113, 2'b00};
        tbl[1] = '{32'h0000_0004, 32'h00C0_0193, 2'b00};
        tbl[2] = '{32'h0000_0008, 32'hFF71_8393, 2'b00};
        tbl[3] = '{32'h0000_0006, NOP,           2'b01};
        tbl[4] = '{32'h0000_0100, NOP,           2'b10};
        tbl[5] = '{32'h0000_0103, NOP,           2'b01};
        tbl[6] = '{32'hFFFF_FFFC, NOP,           2'b10};
        tbl[7] = '{32'h0000_0002, NOP,           2'b01};
        tbl[8] = '{32'h0000_00FC, NOP,           2'b10};
        tbl[9] = '{32'h0000_0004, 32'h00C0_0193, 2'b00};
        tbl[8].addr = 32'h0000_0104;

        n_cmp = 0; n_mis = 0; done_cnt = 0; ld_idx = 0; exp_valid = 1'b0;
        nxt_data = '0; nxt_fault = '0;
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_addr = '0; rsp_ready = 1'b1;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        foreach (mm[i]) mm[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_ld_done", 32'(ld_done), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        rst_n = 1'b1;

        // T1: load with a fetch accepted in the ld_start cycle, then table of fetches
        fetch_valid = 1'b1; fetch_addr = 32'h100; fetch_exp(32'h100);
        done_cnt = 0;
        ld_pulse();
        chk("t1_fetch_with_start", 32'(fr_s), 32'd1);
        fetch_valid = 1'b0;
        ld_beat(32'h0050_0113, 1'b0, 1'b1);
        ld_beat(32'h00C0_0193, 1'b0, 1'b1);
        ld_beat(32'hFF71_8393, 1'b1, 1'b1);
        repeat (2) cycle();
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        rsp_ready = 1'b1;
        foreach (tbl[i]) begin
            fetch_valid = 1'b1;
            fetch_addr  = tbl[i].addr;
            nxt_data    = tbl[i].data;
            nxt_fault   = tbl[i].fault;
            cycle();
            chk("tbl_fetch_ready", 32'(fr_s), 32'd1);
        end
        fetch_valid = 1'b0;
        repeat (2) cycle();

        // T3: stalled response holds and blocks further fetches
        rsp_ready = 1'b0;
        fetch_one(32'h4, "t3_accept");
        fetch_addr = 32'h8; fetch_exp(32'h8);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_fetch_ready_stall", 32'(fr_s), 32'd0);
        end
        fetch_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) cycle();

        // T4: restart mid-load, then a full load that ends without ld_last
        done_cnt = 0;
        ld_pulse();
        ld_beat(32'hDEAD_BEEF, 1'b0, 1'b1);
        ld_start = 1'b1;
        ld_beat(32'hBADB_AD00, 1'b0, 1'b0);
        ld_start = 1'b0; ld_idx = 0;
        for (int i = 0; i < DEPTH; i++) ld_beat(32'h0A00_0000 + 32'(i), 1'b0, 1'b1);
        ld_beat(32'h0BAD_0000, 1'b0, 1'b0);
        cycle();
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        fetch_one(32'h0, "t4_f0");
        fetch_one(32'hFC, "t4_f63");
        fetch_one(32'h80, "t4_f32");
        fetch_valid = 1'b0;
        repeat (2) cycle();

        // T5: reset in the middle of a load
        ld_pulse();
        ld_beat(32'h1111_0001, 1'b0, 1'b1);
        ld_beat(32'h2222_0002, 1'b0, 1'b1);
        ld_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("t5_rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_ld_done", 32'(ld_done), 32'd0);
        chk("t5_rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1; ld_valid = 1'b0;
        exp_valid = 1'b0; sb.delete();
        fetch_one(32'h4, "t5_f1");
        fetch_valid = 1'b0;
        repeat (2) cycle();

        // T6: ld_start while a response is stalled; it drains with its pre-load word
        rsp_ready = 1'b0; done_cnt = 0;
        fetch_one(32'h0, "t6_accept");
        fetch_addr = 32'h4; fetch_exp(32'h4);
        ld_pulse();
        chk("t6_fetch_ready_stalled", 32'(fr_s), 32'd0);
        rsp_ready = 1'b1;
        ld_beat(32'h3333_0003, 1'b0, 1'b1);
        chk("t6_fetch_ready_load", 32'(fr_s), 32'd0);
        ld_beat(32'h4444_0004, 1'b1, 1'b1);
        chk("t6_fetch_ready_last", 32'(fr_s), 32'd0);
        fetch_valid = 1'b0;
        cycle();
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        fetch_one(32'h0, "t6_f0");
        fetch_one(32'h4, "t6_f1");
        fetch_valid = 1'b0;
        repeat (2) cycle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
